bool_sweep_unit: RTL and testbench
==================================

Name: bool_sweep_unit

Overview:
Parametrised sequential successor to the team's 4-input function F = (AB' + A'B)(C + D'). The combinational evaluator is generalised to N inputs. A start/busy/done sequencer sweeps all 2^N input codes, one per clock, and streams each (index, F) pair. It accumulates a minterm count plus the first and last minterm index, giving on-chip self-check data instead of a bench-driven loop. It also provides a registered single-shot evaluation path for arbitrary inputs.

Parameters:
N, 4, number of function inputs; even, 4..16. Upper half U = x[N-1:N/2], lower half L = x[N/2-1:0].
CW, N+1, width of the minterm counter; must hold the value 2^N.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a sweep; sampled only in IDLE
hold  in  1  stalls the sweep while high; no index advance and no output change
eval_in  in  N  operand for single-shot evaluation
eval_f  out  1  registered F(eval_in); 1-cycle latency, updates every cycle including during a sweep
busy  out  1  high in SWEEP
out_valid  out  1  high when out_idx/out_f hold a new sweep sample this cycle
out_idx  out  N  current sweep input code
out_f  out  1  F(out_idx)
done  out  1  one-cycle pulse after the last sample
ones_cnt  out  CW  number of codes with F=1 in the last completed sweep
first_mt  out  N  lowest code with F=1; 0 if none
last_mt  out  N  highest code with F=1; 0 if none

Behaviour:
- Function: F(x) = (^U) & (L != 1). For N=4 (A=x3, B=x2, C=x1, D=x0) this equals (AB'+A'B)(C+D') exactly.
- Reset (asynchronous, any state):
  - State = IDLE.
  - busy, out_valid, done, out_f, eval_f = 0.
  - out_idx, ones_cnt, first_mt, last_mt = 0.
  - Any in-progress sweep is abandoned; no done pulse is issued.
- States: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when start=1 at the clock edge.
    - The next cycle shows busy=1, out_valid=1, out_idx=0, out_f=F(0).
    - The internal accumulators clear on entry. Visible ones_cnt/first_mt/last_mt keep the previous sweep's results until DONE.
  - SWEEP, hold=0: each edge advances out_idx by 1 with out_valid=1.
  - SWEEP, hold=1: out_valid=0; out_idx and accumulators are frozen. The sample is re-presented with out_valid=1 when hold falls.
  - SWEEP -> DONE on the edge after the sample out_idx=2^N-1 is presented with hold=0. No wrap to 0 is ever shown as valid.
  - DONE:
    - busy=0, out_valid=0, done=1 for exactly one cycle.
    - ones_cnt, first_mt, last_mt are updated to final values in this cycle and hold until the next sweep's DONE.
  - DONE -> IDLE unconditionally. A start asserted during DONE is ignored.
- start while busy: ignored, no restart.
- hold in IDLE or DONE: no effect.
- Accumulation, applied on each valid sample with out_f=1:
  - ones_cnt increments.
  - first_mt captures the index only if it is the first 1 of the sweep.
  - last_mt captures the index every time.
  - Counter width CW prevents overflow at the all-ones count 2^N.
- Sweep duration with no hold: 2^N valid cycles, then 1 DONE cycle. Start-to-done latency is 2^N + 1 cycles after the start edge.
- eval path: independent of the FSM; eval_f(t+1) = F(eval_in(t)).

Test Plan:
- N=4, assert rst for 2 cycles mid-operation, then release. Expect all outputs 0, busy=0, and no done pulse.
- N=4, pulse start. Expect:
  - 16 valid samples, idx 0..15.
  - out_f=1 exactly at idx 4, 6, 7, 8, 10, 11.
  - done pulses on cycle 17 after the start edge, with ones_cnt=6, first_mt=4, last_mt=11.
- N=4, raise hold for 3 cycles at idx=7. Expect out_valid=0 for 3 cycles, then idx=7 re-presented, no skipped or duplicate valid samples, ones_cnt=6, and done delayed by 3 cycles.
- N=4, pulse start again at idx=5 and during the DONE cycle. Expect both ignored: a single sweep and a single done pulse.
- N=4, assert rst at idx=9, then start a new sweep. Expect no done from the aborted sweep; the fresh sweep reports ones_cnt=6, first_mt=4, last_mt=11.
- N=6, run a full sweep. Expect ones_cnt=28, first_mt=8, last_mt=63, done 65 cycles after start. Separately drive eval_in=6'b001000 and 6'b001001: eval_f = 1 and 0 one cycle later.

Source files
------------

// File: rtl/bool_sweep_unit.sv
// Evaluates F(x) = (^U) & (L != 1) on N inputs. The unit can sweep all 2^N codes
// and stream the results, and it has a registered single-shot evaluation path.
module bool_sweep_unit #(
    parameter int N  = 4,
    parameter int CW = N + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    input  logic [N-1:0]  eval_in,
    output logic          eval_f,
    output logic          busy,
    output logic          out_valid,
    output logic [N-1:0]  out_idx,
    output logic          out_f,
    output logic          done,
    output logic [CW-1:0] ones_cnt,
    output logic [N-1:0]  first_mt,
    output logic [N-1:0]  last_mt
);
    localparam int H = N / 2;

    function automatic logic f_of(input logic [N-1:0] x);
        return (^x[N-1:H]) & (x[H-1:0] != H'(1));
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  idx;
    logic [CW-1:0] acc_cnt, cnt_nxt;
    logic [N-1:0]  acc_first, first_nxt, acc_last, last_nxt;
    logic          acc_seen, seen_nxt;
    logic          advance, hit;

    // A sample is consumed only on an edge where the sweep is running and not held.
    assign advance   = (state == S_SWEEP) && !hold;
    assign hit       = advance && f_of(idx);

    assign busy      = (state == S_SWEEP);
    assign out_valid = advance;
    assign out_idx   = idx;
    assign out_f     = f_of(idx);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_SWEEP;
            S_SWEEP: if (advance && idx == '1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Running statistics including the sample consumed at this edge.
    always_comb begin
        cnt_nxt   = acc_cnt;
        first_nxt = acc_first;
        last_nxt  = acc_last;
        seen_nxt  = acc_seen;
        if (hit) begin
            cnt_nxt  = acc_cnt + CW'(1);
            last_nxt = idx;
            if (!acc_seen) begin
                first_nxt = idx;
                seen_nxt  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_f    <= 1'b0;
            idx       <= '0;
            acc_cnt   <= '0;
            acc_first <= '0;
            acc_last  <= '0;
            acc_seen  <= 1'b0;
            ones_cnt  <= '0;
            first_mt  <= '0;
            last_mt   <= '0;
        end else begin
            eval_f <= f_of(eval_in);
            if (state == S_IDLE && start) begin
                idx       <= '0;
                acc_cnt   <= '0;
                acc_first <= '0;
                acc_last  <= '0;
                acc_seen  <= 1'b0;
            end else if (advance) begin
                // The counter wraps to 0 after the last code, but that edge enters DONE,
                // where out_valid is low.
                idx       <= idx + N'(1);
                acc_cnt   <= cnt_nxt;
                acc_first <= first_nxt;
                acc_last  <= last_nxt;
                acc_seen  <= seen_nxt;
                if (idx == '1) begin
                    ones_cnt <= cnt_nxt;
                    first_mt <= first_nxt;
                    last_mt  <= last_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_bool_sweep_unit.sv
// Bench for bool_sweep_unit at N=4 and N=6. It checks the results against a
// reference model built directly from the function definition.
module tb_bool_sweep_unit;
    logic clk = 1'b0;
    logic rst;

    logic       start4, hold4, eval_f4, busy4, valid4, f4, done4;
    logic [3:0] eval4, idx4, first4, last4;
    logic [4:0] cnt4;

    logic       start6, hold6, eval_f6, busy6, valid6, f6, done6;
    logic [5:0] eval6, idx6, first6, last6;
    logic [6:0] cnt6;

    int tests = 0;
    int fails = 0;
    int prev_cnt4 = 0;

    always #5 clk = ~clk;

    bool_sweep_unit #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .hold(hold4), .eval_in(eval4),
        .eval_f(eval_f4), .busy(busy4), .out_valid(valid4), .out_idx(idx4),
        .out_f(f4), .done(done4), .ones_cnt(cnt4), .first_mt(first4), .last_mt(last4)
    );

    bool_sweep_unit #(.N(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .hold(hold6), .eval_in(eval6),
        .eval_f(eval_f6), .busy(busy6), .out_valid(valid6), .out_idx(idx6),
        .out_f(f6), .done(done6), .ones_cnt(cnt6), .first_mt(first6), .last_mt(last6)
    );

    // F is 1 when the upper half has odd parity and the lower half is not equal to 1.
    function automatic bit ref_f(input int n, input int x);
        int u, l;
        u = x >> (n / 2);
        l = x % (1 << (n / 2));
        return ($countones(u) % 2 == 1) && (l != 1);
    endfunction

    task automatic ref_stats(input int n, output int cnt, output int first, output int last);
        cnt = 0; first = 0; last = 0;
        for (int x = 0; x < (1 << n); x++)
            if (ref_f(n, x)) begin
                if (cnt == 0) first = x;
                last = x;
                cnt++;
            end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Run one N=4 sweep. The task is entered one step after a posedge while the DUT is idle.
    task automatic run_sweep4(input string name, input int hold_at, input int hold_len,
                              input bit rand_hold, input int restart_idx, input bit start_in_done);
        int q_idx[$];
        int q_f[$];
        int holds = 0, held = 0, done_cyc = -1, extra = 0;
        int cnt, first, last;
        ref_stats(4, cnt, first, last);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check({name, "_stats_kept"}, cnt4, prev_cnt4);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            hold4 = 1'b0;
            if (busy4) begin
                if (rand_hold) hold4 = ($urandom_range(0, 3) == 0);
                else if (idx4 == hold_at && held < hold_len) begin
                    hold4 = 1'b1;
                    held++;
                end
            end
            if (hold4) holds++;
            start4 = (busy4 && idx4 == restart_idx) || (start_in_done && done4);
            #1;
            if (valid4) begin
                q_idx.push_back(idx4);
                q_f.push_back(f4);
            end
            if (done4) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_done_cycle"}, done_cyc, 17 + holds);
        check({name, "_n_samples"}, q_idx.size(), 16);
        for (int i = 0; i < q_idx.size() && i < 16; i++) begin
            check($sformatf("%s_idx%0d", name, i), q_idx[i], i);
            check($sformatf("%s_f%0d", name, i), q_f[i], int'(ref_f(4, i)));
        end
        check({name, "_ones_cnt"}, cnt4, cnt);
        check({name, "_first_mt"}, first4, first);
        check({name, "_last_mt"}, last4, last);
        prev_cnt4 = cnt;
        @(posedge clk); #1;
        start4 = 1'b0;
        hold4  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy4 || done4 || valid4) extra++;
            @(posedge clk); #1;
        end
        check({name, "_quiet_after"}, extra, 0);
    endtask

    typedef struct {
        int n;
        int x;
        bit f;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int cnt6_exp, first6_exp, last6_exp, done_cyc, nvalid, ones_seen, bad;

        vecs[0] = '{4, 4'h4, 1'b1};
        vecs[1] = '{4, 4'h5, 1'b0};
        vecs[2] = '{4, 4'h0, 1'b0};
        vecs[3] = '{4, 4'hB, 1'b1};
        vecs[4] = '{4, 4'hD, 1'b0};
        vecs[5] = '{4, 4'hF, 1'b0};
        vecs[6] = '{4, 4'h9, 1'b0};
        vecs[7] = '{4, 4'h8, 1'b1};
        vecs[8] = '{6, 6'b001000, 1'b1};
        vecs[9] = '{6, 6'b001001, 1'b0};

        rst = 1'b1;
        {start4, hold4, eval4, start6, hold6, eval6} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy4, 0);
        check("reset_valid", valid4, 0);
        check("reset_done", done4, 0);
        check("reset_idx", idx4, 0);
        check("reset_cnt", cnt4, 0);
        check("reset_first_last", {first4, last4}, 0);
        check("reset_f", {f4, eval_f4}, 0);
        check("reset_n6", {busy6, done6, cnt6, first6, last6, idx6}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].n == 4) eval4 = 4'(vecs[i].x);
            else                eval6 = 6'(vecs[i].x);
            @(posedge clk); #1;
            if (vecs[i].n == 4) check($sformatf("vec4_%0d", vecs[i].x), eval_f4, int'(vecs[i].f));
            else                check($sformatf("vec6_%0d", vecs[i].x), eval_f6, int'(vecs[i].f));
        end

        for (int i = 0; i < 30; i++) begin
            eval4 = 4'($urandom);
            eval6 = 6'($urandom);
            @(posedge clk); #1;
            check($sformatf("rand_eval4_%0d", eval4), eval_f4, int'(ref_f(4, eval4)));
            check($sformatf("rand_eval6_%0d", eval6), eval_f6, int'(ref_f(6, eval6)));
        end

        run_sweep4("plain", -1, 0, 1'b0, -1, 1'b0);
        run_sweep4("hold7", 7, 3, 1'b0, -1, 1'b0);
        run_sweep4("restart", -1, 0, 1'b0, 5, 1'b1);
        run_sweep4("randhold", -1, 0, 1'b1, -1, 1'b0);

        // An asynchronous reset in the middle of a sweep.
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 40 && idx4 != 4'd9; i++) begin
            @(posedge clk); #1;
        end
        check("abort_reached_idx9", idx4, 9);
        rst = 1'b1;
        #1;
        check("abort_async_busy", busy4, 0);
        check("abort_async_state", {valid4, done4, idx4, cnt4, first4, last4}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy4 || done4) bad++;
            @(posedge clk); #1;
        end
        check("abort_no_done", bad, 0);
        prev_cnt4 = 0;
        run_sweep4("fresh", -1, 0, 1'b0, -1, 1'b0);

        // Full N=6 sweep.
        ref_stats(6, cnt6_exp, first6_exp, last6_exp);
        start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        done_cyc = -1; nvalid = 0; ones_seen = 0; bad = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (valid6) begin
                if (idx6 != 6'(nvalid) || f6 != ref_f(6, nvalid)) bad++;
                nvalid++;
                if (f6) ones_seen++;
            end
            if (done6) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check("n6_done_cycle", done_cyc, 65);
        check("n6_n_samples", nvalid, 64);
        check("n6_sample_errors", bad, 0);
        check("n6_stream_ones", ones_seen, 28);
        check("n6_ones_cnt", cnt6, cnt6_exp);
        check("n6_first_mt", first6, first6_exp);
        check("n6_last_mt", last6, last6_exp);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
